wb_write_scheduler: RTL and testbench

//  Serialises write-back requests from two pipeline sources onto the single register-file write port.
//  - Sources: ALU results and late SRAM load data.
//  - Register-file port: writeBackEn / Dest_wb / Result_WB, which the register file samples on the falling clock edge.
//  - Collisions and port-busy cycles are absorbed by a small ordered queue.
//  - Exports a pending-destination mask for the hazard unit.

---
 rtl/wb_write_scheduler_if.sv | 25 ++
 rtl/wb_write_scheduler.sv | 142 ++++++++++++++
 tb/tb_wb_write_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/wb_write_scheduler_if.sv
// rtl/wb_write_scheduler_if.sv - write-back request and register-file port bundle
interface wb_write_scheduler_if;
  logic        ld_valid;
  logic [3:0]  ld_dest;
  logic [31:0] ld_data;
  logic        alu_valid;
  logic [3:0]  alu_dest;
  logic [31:0] alu_result;
  logic        stall;
  logic        writeBackEn;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;
  logic [15:0] pending_mask;
  logic        overflow;

  modport master (
    output ld_valid, ld_dest, ld_data, alu_valid, alu_dest, alu_result,
    input  stall, writeBackEn, Dest_wb, Result_WB, pending_mask, overflow
  );

  modport slave (
    input  ld_valid, ld_dest, ld_data, alu_valid, alu_dest, alu_result,
    output stall, writeBackEn, Dest_wb, Result_WB, pending_mask, overflow
  );
endinterface

// File: rtl/wb_write_scheduler.sv
// rtl/wb_write_scheduler.sv - serialises load and ALU write-backs onto one register-file write port
module wb_write_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_write_scheduler_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [3:0]       mem_dest_q [DEPTH];
  logic [3:0]       mem_dest_d [DEPTH];
  logic [31:0]      mem_data_q [DEPTH];
  logic [31:0]      mem_data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wben_q, wben_d;
  logic [3:0]       dest_wb_q, dest_wb_d;
  logic [31:0]      result_q, result_d;
  logic             stall_q, stall_d;
  logic             overflow_q, overflow_d;

  logic             push_ld, push_alu;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] occ;
  logic [15:0]      mask;

  // Pop (or bypass) first, then enqueue ld before alu so a full queue drops alu first.
  always_comb begin
    mem_dest_d = mem_dest_q;
    mem_data_d = mem_data_q;
    valid_d    = valid_q;
    head_d     = head_q;
    overflow_d = overflow_q;
    wben_d     = 1'b0;
    dest_wb_d  = dest_wb_q;
    result_d   = result_q;
    push_ld    = 1'b0;
    push_alu   = 1'b0;
    occ        = count_q;
    wr_ptr     = tail_q;

    if (count_q != '0) begin
      wben_d          = 1'b1;
      dest_wb_d       = mem_dest_q[head_q];
      result_d        = mem_data_q[head_q];
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_ONE;
      occ             = count_q - CNT_ONE;
      push_ld         = bus.ld_valid;
      push_alu        = bus.alu_valid;
    end else if (bus.ld_valid) begin
      wben_d    = 1'b1;
      dest_wb_d = bus.ld_dest;
      result_d  = bus.ld_data;
      push_alu  = bus.alu_valid;
    end else if (bus.alu_valid) begin
      wben_d    = 1'b1;
      dest_wb_d = bus.alu_dest;
      result_d  = bus.alu_result;
    end

    if (push_ld) begin
      if (occ < CNT_FULL) begin
        mem_dest_d[wr_ptr] = bus.ld_dest;
        mem_data_d[wr_ptr] = bus.ld_data;
        valid_d[wr_ptr]    = 1'b1;
        wr_ptr             = wr_ptr + PTR_ONE;
        occ                = occ + CNT_ONE;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (push_alu) begin
      if (occ < CNT_FULL) begin
        mem_dest_d[wr_ptr] = bus.alu_dest;
        mem_data_d[wr_ptr] = bus.alu_result;
        valid_d[wr_ptr]    = 1'b1;
        wr_ptr             = wr_ptr + PTR_ONE;
        occ                = occ + CNT_ONE;
      end else begin
        overflow_d = 1'b1;
      end
    end

    tail_d  = wr_ptr;
    count_d = occ;
    stall_d = (occ >= STALL_LVL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_dest_q <= '{default: '0};
      mem_data_q <= '{default: '0};
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wben_q     <= 1'b0;
      dest_wb_q  <= '0;
      result_q   <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      mem_dest_q <= mem_dest_d;
      mem_data_q <= mem_data_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wben_q     <= wben_d;
      dest_wb_q  <= dest_wb_d;
      result_q   <= result_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  // Hazard view: everything queued plus the write currently on the port.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) mask[mem_dest_q[i]] = 1'b1;
    end
    if (wben_q) mask[dest_wb_q] = 1'b1;
  end

  assign bus.stall        = stall_q;
  assign bus.writeBackEn  = wben_q;
  assign bus.Dest_wb      = dest_wb_q;
  assign bus.Result_WB    = result_q;
  assign bus.pending_mask = mask;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_wb_write_scheduler.sv
// tb/tb_wb_write_scheduler.sv - self-checking bench for wb_write_scheduler against a queue model
module tb_wb_write_scheduler;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_write_scheduler_if bus ();
  wb_write_scheduler #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  wr_t         q[$];
  logic        exp_en, exp_stall, exp_ovf;
  logic [3:0]  exp_dest;
  logic [31:0] exp_data;
  int          checks = 0;
  int          errors = 0;
  wr_t         none = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_mask();
    logic [15:0] m = '0;
    foreach (q[i]) m[q[i].dest] = 1'b1;
    if (exp_en) m[exp_dest] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_en = 0; exp_stall = 0; exp_ovf = 0; exp_dest = '0; exp_data = '0;
  endtask

  // One write per edge from the oldest source; the rest join the queue while it has room.
  task automatic model_step(input logic lv, input wr_t l, input logic av, input wr_t a);
    wr_t inc[$];
    wr_t w;
    if (lv) inc.push_back(l);
    if (av) inc.push_back(a);
    exp_en = 0;
    if (q.size() != 0) begin
      w = q.pop_front(); exp_en = 1;
    end else if (inc.size() != 0) begin
      w = inc.pop_front(); exp_en = 1;
    end
    if (exp_en) begin exp_dest = w.dest; exp_data = w.data; end
    foreach (inc[i]) begin
      if (q.size() < DEPTH) q.push_back(inc[i]);
      else exp_ovf = 1;
    end
    exp_stall = (q.size() >= DEPTH - 1);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_en"},    32'(bus.writeBackEn),  32'(exp_en));
    chk({tag, "_dest"},  32'(bus.Dest_wb),      32'(exp_dest));
    chk({tag, "_data"},  bus.Result_WB,         exp_data);
    chk({tag, "_stall"}, 32'(bus.stall),        32'(exp_stall));
    chk({tag, "_ovf"},   32'(bus.overflow),     32'(exp_ovf));
    chk({tag, "_mask"},  32'(bus.pending_mask), 32'(model_mask()));
  endtask

  task automatic cycle(input logic lv, input wr_t l, input logic av, input wr_t a, input string tag);
    bus.ld_valid  = lv;  bus.ld_dest  = l.dest; bus.ld_data    = l.data;
    bus.alu_valid = av;  bus.alu_dest = a.dest; bus.alu_result = a.data;
    @(posedge clk);
    model_step(lv, l, av, a);
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic wr_t rnd();
    wr_t w;
    w.dest = 4'($urandom_range(0, 15));
    w.data = $urandom;
    return w;
  endfunction

  task automatic drain(input string tag);
    int guard = 0;
    while (q.size() != 0 && guard < 2 * DEPTH + 4) begin
      cycle(0, none, 0, none, tag);
      guard++;
    end
    chk({tag, "_drained"}, 32'(q.size()), 32'd0);
    cycle(0, none, 0, none, tag);
  endtask

  initial begin
    wr_t a, l;
    logic saw_stall;
    int sent, guard;

    rst = 1'b0;
    bus.ld_valid = 0; bus.ld_dest = '0; bus.ld_data = '0;
    bus.alu_valid = 0; bus.alu_dest = '0; bus.alu_result = '0;
    model_reset();
    #1 check_all("reset0");
    @(negedge clk) rst = 1'b1;

    // Single ALU write with empty queue goes straight to the port.
    a.dest = 4'd5; a.data = 32'hDEADBEEF;
    cycle(0, none, 1, a, "single");
    chk("single_data_const", bus.Result_WB, 32'hDEADBEEF);
    cycle(0, none, 0, none, "single_idle");
    chk("single_idle_en", 32'(bus.writeBackEn), 32'd0);

    // Same-cycle ld and alu to r3: ld first, alu value final.
    l.dest = 4'd3; l.data = 32'h11; a.dest = 4'd3; a.data = 32'h22;
    cycle(1, l, 1, a, "same_dest");
    chk("same_dest_mask3_a", 32'(bus.pending_mask[3]), 32'd1);
    cycle(0, none, 0, none, "same_dest_2");
    chk("same_dest_second", bus.Result_WB, 32'h22);
    chk("same_dest_mask3_b", 32'(bus.pending_mask[3]), 32'd1);
    cycle(0, none, 0, none, "same_dest_idle");

    // Dual requests while honouring stall: no overflow.
    sent = 0; guard = 0; saw_stall = 0;
    while (sent < 10 && guard < 60) begin
      if (exp_stall) cycle(0, none, 0, none, "honour_wait");
      else begin
        cycle(1, rnd(), 1, rnd(), "honour");
        sent += 2;
      end
      if (bus.stall) saw_stall = 1;
      guard++;
    end
    chk("honour_sent", 32'(sent), 32'd10);
    chk("honour_stall_seen", 32'(saw_stall), 32'd1);
    drain("honour_drain");
    chk("honour_no_ovf", 32'(bus.overflow), 32'd0);

    // Ignore stall: queue overflows and drops alu first.
    for (int i = 0; i < 6; i++) cycle(1, rnd(), 1, rnd(), "ignore");
    drain("ignore_drain");
    chk("ignore_ovf", 32'(bus.overflow), 32'd1);

    // Build up three queued entries, then reset asynchronously mid-cycle.
    cycle(1, rnd(), 1, rnd(), "prefill");
    cycle(1, rnd(), 1, rnd(), "prefill");
    cycle(1, rnd(), 1, rnd(), "prefill");
    chk("prefill_depth", 32'(q.size()), 32'd3);
    bus.ld_valid = 0; bus.alu_valid = 0;
    rst = 1'b0;
    model_reset();
    #1 check_all("async_reset");
    @(negedge clk) rst = 1'b1;
    cycle(0, none, 0, none, "post_reset");

    // Steady push/pop keeps one entry queued while pointers wrap.
    cycle(1, rnd(), 1, rnd(), "wrap_seed");
    for (int i = 0; i < 3 * DEPTH + 4; i++) begin
      if ($urandom_range(0, 1) == 0) cycle(1, rnd(), 0, none, "wrap");
      else cycle(0, none, 1, rnd(), "wrap");
    end
    drain("wrap_drain");

    // Random mix of request patterns, honouring stall.
    for (int i = 0; i < 60; i++) begin
      if (exp_stall) cycle(0, none, 0, none, "mix_wait");
      else cycle(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)), rnd(), "mix");
    end
    drain("mix_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
